// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types, key codes and helpers for the enemy direction generator
package enemy_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE_ST,
        WALK_ST,
        PAUSE_ST,
        TURN_ST
    } state_t;

    localparam logic [3:0] KEY_UP    = 4'b1000;
    localparam logic [3:0] KEY_DOWN  = 4'b0010;
    localparam logic [3:0] KEY_LEFT  = 4'b0100;
    localparam logic [3:0] KEY_RIGHT = 4'b0110;
    localparam logic [3:0] KEY_NONE  = 4'b0000;

    function automatic logic [3:0] dir_to_key(input dir_t d);
        case (d)
            DIR_UP:    return KEY_UP;
            DIR_RIGHT: return KEY_RIGHT;
            DIR_DOWN:  return KEY_DOWN;
            DIR_LEFT:  return KEY_LEFT;
            default:   return KEY_NONE;
        endcase
    endfunction

    // HitEdgeCode bit that blocks travel in direction d: [3]=left [2]=top [1]=right [0]=bottom
    function automatic logic [3:0] dir_to_edge(input dir_t d);
        case (d)
            DIR_UP:    return 4'b0100;
            DIR_RIGHT: return 4'b0010;
            DIR_DOWN:  return 4'b0001;
            DIR_LEFT:  return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/enemy_dir_gen_lfsr16.sv
// rtl/enemy_dir_gen_lfsr16.sv - free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // An all-zero state would lock up the register
    localparam logic [15:0] START = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= START;
        end else begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/enemy_dir_gen.sv
// rtl/enemy_dir_gen.sv - autonomous key/keyIsPressed source that random-walks an enemy sprite
module enemy_dir_gen
    import enemy_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          MIN_WALK_FRAMES = 16,
    parameter int          WALK_RAND_BITS  = 5,
    parameter bit          PAUSE_EN        = 1'b1,
    parameter int          PAUSE_FRAMES    = 8,
    parameter int          INITIAL_DIR     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       enable,
    input  logic       collision,
    input  logic [3:0] HitEdgeCode,
    output logic [3:0] key,
    output logic       keyIsPressed
);

    localparam dir_t        INIT_DIR   = dir_t'(INITIAL_DIR[1:0]);
    localparam logic [16:0] MIN_WALK   = 17'(MIN_WALK_FRAMES);
    localparam logic [15:0] RAND_MASK  = 16'((1 << WALK_RAND_BITS) - 1);
    localparam logic [7:0]  PAUSE_LOAD = 8'(PAUSE_FRAMES);

    logic [15:0] w_lfsr;
    logic [16:0] w_walk_sum;
    logic [7:0]  w_walk_load;
    logic [7:0]  w_walk_dec;
    logic [7:0]  w_pause_dec;
    logic        w_blocked;
    logic [1:0]  w_try;
    dir_t        w_turn_dir;

    state_t      r_state;
    dir_t        r_dir;
    logic [3:0]  r_mask;
    logic [7:0]  r_walk_cnt;
    logic [7:0]  r_pause_cnt;
    logic [3:0]  r_key;
    logic        r_kip;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    // Segment length saturates at 255 when MIN plus the random extra overflows 8 bits
    assign w_walk_sum  = MIN_WALK + {1'b0, w_lfsr & RAND_MASK};
    assign w_walk_load = (|w_walk_sum[16:8]) ? 8'hFF : w_walk_sum[7:0];
    assign w_walk_dec  = (r_walk_cnt == 8'd0) ? 8'd0 : r_walk_cnt - 8'd1;
    assign w_pause_dec = (r_pause_cnt == 8'd0) ? 8'd0 : r_pause_cnt - 8'd1;
    assign w_blocked   = |(HitEdgeCode & dir_to_edge(r_dir));

    // Walk offsets 3..0 so the smallest unblocked offset from the candidate wins
    always_comb begin
        w_turn_dir = r_dir;
        w_try      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_try = w_lfsr[1:0] + 2'(i);
            if (!r_mask[w_try]) begin
                w_turn_dir = dir_t'(w_try);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE_ST;
            r_dir       <= INIT_DIR;
            r_mask      <= 4'b0000;
            r_walk_cnt  <= 8'd0;
            r_pause_cnt <= 8'd0;
            r_key       <= KEY_NONE;
            r_kip       <= 1'b0;
        end else begin
            // Outputs follow the state register, so they trail each transition by one clock
            case (r_state)
                IDLE_ST: begin
                    r_key <= KEY_NONE;
                    r_kip <= 1'b0;
                end
                WALK_ST: begin
                    r_key <= dir_to_key(r_dir);
                    r_kip <= 1'b1;
                end
                PAUSE_ST: r_kip <= 1'b0;
                default: ;
            endcase

            if (r_state == IDLE_ST) begin
                r_dir  <= INIT_DIR;
                r_mask <= 4'b0000;
            end

            if (!enable) begin
                r_state <= IDLE_ST;
            end else begin
                case (r_state)
                    IDLE_ST: begin
                        if (startOfFrame) begin
                            r_walk_cnt <= w_walk_load;
                            r_state    <= WALK_ST;
                        end
                    end
                    WALK_ST: begin
                        if (collision && w_blocked) begin
                            r_mask[r_dir] <= 1'b1;
                            r_state       <= TURN_ST;
                        end else if (startOfFrame) begin
                            r_walk_cnt <= w_walk_dec;
                            if (r_walk_cnt <= 8'd1) begin
                                r_mask      <= 4'b0000;
                                r_pause_cnt <= PAUSE_LOAD;
                                r_state     <= (PAUSE_EN && w_lfsr[15]) ? PAUSE_ST : TURN_ST;
                            end
                        end
                    end
                    PAUSE_ST: begin
                        if (startOfFrame) begin
                            r_pause_cnt <= w_pause_dec;
                            if (r_pause_cnt <= 8'd1) begin
                                r_state <= TURN_ST;
                            end
                        end
                    end
                    default: begin
                        // Boxed in on all four sides: back out the way we came
                        if (r_mask == 4'b1111) begin
                            r_dir  <= dir_t'(r_dir + 2'd2);
                            r_mask <= 4'b0000;
                        end else begin
                            r_dir <= w_turn_dir;
                        end
                        r_walk_cnt <= w_walk_load;
                        r_state    <= WALK_ST;
                    end
                endcase
            end
        end
    end

    assign key          = r_key;
    assign keyIsPressed = r_kip;

endmodule

// File: tb/tb_enemy_dir_gen.sv
// tb/tb_enemy_dir_gen.sv - self-checking bench for enemy_dir_gen with a frame-level reference model
module tb_enemy_dir_gen;

    logic       clk;
    logic       reset;
    logic       sof;
    logic       collision;
    logic [3:0] hit_edge;
    logic       en_a, en_b, en_c;
    logic [3:0] key_a, key_b, key_c;
    logic       kip_a, kip_b, kip_c;
    logic [15:0] m_lfsr;
    int n_checks;
    int n_fail;

    enemy_dir_gen #(.LFSR_SEED(16'hACE1), .MIN_WALK_FRAMES(4), .WALK_RAND_BITS(0),
                    .PAUSE_EN(1'b0), .PAUSE_FRAMES(8), .INITIAL_DIR(0)) u_a (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en_a), .collision(collision),
        .HitEdgeCode(hit_edge), .key(key_a), .keyIsPressed(kip_a));

    enemy_dir_gen #(.LFSR_SEED(16'hACE1), .MIN_WALK_FRAMES(200), .WALK_RAND_BITS(0),
                    .PAUSE_EN(1'b0), .PAUSE_FRAMES(8), .INITIAL_DIR(3)) u_b (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en_b), .collision(collision),
        .HitEdgeCode(hit_edge), .key(key_b), .keyIsPressed(kip_b));

    enemy_dir_gen #(.LFSR_SEED(16'hACE1), .MIN_WALK_FRAMES(16), .WALK_RAND_BITS(5),
                    .PAUSE_EN(1'b1), .PAUSE_FRAMES(8), .INITIAL_DIR(0)) u_c (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en_c), .collision(collision),
        .HitEdgeCode(hit_edge), .key(key_c), .keyIsPressed(kip_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [3:0] key_of(input int d);
        case (d)
            0: return 4'b1000;
            1: return 4'b0110;
            2: return 4'b0010;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic logic [3:0] edge_of(input int d);
        case (d)
            0: return 4'b0100;
            1: return 4'b0010;
            2: return 4'b0001;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic int pick_dir(input int c, input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (!mask[(c + i) % 4]) return (c + i) % 4;
        end
        return c;
    endfunction

    // Free-running reference LFSR: equals the DUT register between clock edges
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic test_reset();
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (key_a !== 4'b0000 || kip_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: key=%b kip=%b want 0000/0", key_a, kip_a);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse_sof();
            @(negedge clk);
            n_checks++;
            if (key_a !== 4'b0000 || kip_a !== 1'b0 || key_c !== 4'b0000 || kip_c !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_sof%0d: a=%b/%b c=%b/%b want 0000/0", i, key_a, kip_a, key_c, kip_c);
            end
        end
        en_a = 1'b1;
        pulse_sof();
        repeat (2) @(negedge clk);
        n_checks++;
        if (key_a !== 4'b1000 || kip_a !== 1'b1) begin
            n_fail++; $display("FAIL walk_before_reset: key=%b kip=%b want 1000/1", key_a, kip_a);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (key_a !== 4'b0000 || kip_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_walk: key=%b kip=%b want 0000/0", key_a, kip_a);
        end
        reset = 1'b0;
        pulse_sof();
        repeat (2) @(negedge clk);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (key_a !== 4'b0000 || kip_a !== 1'b0) begin
            n_fail++; $display("FAIL disable_mid_walk: key=%b kip=%b want 0000/0", key_a, kip_a);
        end
    endtask

    // Four-frame segments; each SOF is timed so a turn would land on a direction other than UP
    task automatic walk_four(input bit with_collisions);
        logic [15:0] nxt;
        nxt = 16'h0;
        for (int i = 0; i < 4; i++) begin
            if (with_collisions && i == 2) begin
                collision = 1'b1; hit_edge = 4'b1011;
                @(negedge clk);
                collision = 1'b0; hit_edge = 4'b0000;
            end
            for (int w = 0; w < 64; w++) begin
                nxt = lfsr_step(m_lfsr);
                if (nxt[1:0] != 2'd0) break;
                @(negedge clk);
            end
            n_checks++;
            if (key_a !== 4'b1000 || kip_a !== 1'b1) begin
                n_fail++; $display("FAIL walk_hold_sof%0d: key=%b kip=%b want 1000/1", i, key_a, kip_a);
            end
            if (with_collisions && i == 2) begin
                collision = 1'b1; hit_edge = 4'b1001;
            end
            pulse_sof();
            collision = 1'b0; hit_edge = 4'b0000;
            repeat (2) @(negedge clk);
        end
        n_checks++;
        if (key_a !== key_of(int'(nxt[1:0])) || kip_a !== 1'b1) begin
            n_fail++;
            $display("FAIL walk_turn: key=%b kip=%b want %b/1", key_a, kip_a, key_of(int'(nxt[1:0])));
        end
    endtask

    task automatic test_fixed_walk();
        do_reset();
        en_a = 1'b1;
        pulse_sof();
        @(negedge clk);
        n_checks++;
        if (key_a !== 4'b1000 || kip_a !== 1'b1) begin
            n_fail++; $display("FAIL walk_start: key=%b kip=%b want 1000/1", key_a, kip_a);
        end
        walk_four(1'b0);
        en_a = 1'b0;
    endtask

    task automatic test_nonmatch_collision();
        do_reset();
        en_a = 1'b1;
        pulse_sof();
        @(negedge clk);
        walk_four(1'b1);
        en_a = 1'b0;
    endtask

    task automatic test_match_collision();
        int exp_dir;
        do_reset();
        en_b = 1'b1;
        pulse_sof();
        repeat (3) @(negedge clk);
        n_checks++;
        if (key_b !== 4'b0100 || kip_b !== 1'b1) begin
            n_fail++; $display("FAIL left_start: key=%b kip=%b want 0100/1", key_b, kip_b);
        end
        collision = 1'b1; hit_edge = 4'b1000;
        @(negedge clk);
        collision = 1'b0; hit_edge = 4'b0000;
        exp_dir = pick_dir(int'(m_lfsr[1:0]), 4'b1000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (key_b !== key_of(exp_dir) || key_b === 4'b0100 || kip_b !== 1'b1) begin
            n_fail++; $display("FAIL left_blocked_turn: key=%b kip=%b want %b/1", key_b, kip_b, key_of(exp_dir));
        end
        en_b = 1'b0;
    endtask

    task automatic test_all_blocked();
        int cur;
        logic [3:0] mask;
        logic [15:0] t;
        do_reset();
        en_b = 1'b1;
        pulse_sof();
        @(negedge clk);
        cur = 3;
        mask = 4'b0000;
        for (int blk = 0; blk < 5; blk++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            collision = 1'b1; hit_edge = edge_of(cur);
            @(negedge clk);
            collision = 1'b0; hit_edge = 4'b0000;
            t = m_lfsr;
            mask[cur] = 1'b1;
            if (mask == 4'b1111) begin
                cur = (cur + 2) % 4;
                mask = 4'b0000;
            end else begin
                cur = pick_dir(int'(t[1:0]), mask);
            end
            repeat (2) @(negedge clk);
            n_checks++;
            if (key_b !== key_of(cur) || kip_b !== 1'b1) begin
                n_fail++; $display("FAIL block%0d_turn: key=%b kip=%b want %b/1", blk, key_b, kip_b, key_of(cur));
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_pause_random();
        int dir, left;
        bit paused;
        logic [15:0] l_now, l_turn;
        do_reset();
        en_c = 1'b1;
        l_now = m_lfsr;
        pulse_sof();
        dir = 0; paused = 1'b0; left = 16 + int'(l_now[4:0]);
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(3, 6)) begin
                if ($urandom_range(0, 3) == 0) begin
                    collision = 1'b1;
                    hit_edge = 4'($urandom_range(0, 15));
                    if (!paused) hit_edge = hit_edge & ~edge_of(dir);
                end else begin
                    collision = 1'b0;
                end
                @(negedge clk);
            end
            collision = 1'b0; hit_edge = 4'b0000;
            n_checks++;
            if (kip_c !== !paused || key_c !== key_of(dir)) begin
                n_fail++;
                $display("FAIL random_sof%0d: key=%b kip=%b want %b/%b", n, key_c, kip_c, key_of(dir), !paused);
            end
            l_now = m_lfsr;
            l_turn = lfsr_step(l_now);
            pulse_sof();
            left--;
            if (left == 0) begin
                if (!paused && l_now[15]) begin
                    paused = 1'b1; left = 8;
                end else begin
                    paused = 1'b0;
                    dir = int'(l_turn[1:0]);
                    left = 16 + int'(l_turn[4:0]);
                end
            end
        end
        en_c = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; sof = 1'b0; collision = 1'b0; hit_edge = 4'b0000;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        test_reset();
        test_fixed_walk();
        test_nonmatch_collision();
        test_match_collision();
        test_all_blocked();
        test_pause_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
